sync_fifo_v2: RTL and testbench

Parametrised successor to the single-clock FIFO. It adds a selectable first-word-fall-through (FWFT) read mode, a full-depth programmable threshold range, and sticky overflow/underflow error flags with a clear input. Optional per-entry parity is compiled in by macro. It is the general-purpose buffering element between producer/consumer pipelines in one clock domain.

---
 rtl/sync_fifo_v2_pkg.sv | 21 ++
 rtl/sync_fifo_v2_if.sv | 58 +++++
 rtl/sync_fifo_v2_ram.sv | 34 +++
 rtl/sync_fifo_v2.sv | 160 ++++++++++++++++
 tb/tb_sync_fifo_v2.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_v2_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2_pkg
// Shared definitions for the sync_fifo_v2 block:
//   FIFO_MODE_STD / FIFO_MODE_FWFT : values for the FWFT read-mode parameter
//   PARITY_MAX_W                   : widest data word the parity helper covers
//   even_parity()                  : parity bit that makes a word's 1-count even
// Optional feature macro used elsewhere: SYNC_FIFO_V2_PARITY_EN
// -----------------------------------------------------------------------------
package sync_fifo_v2_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int PARITY_MAX_W = 64;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo_v2_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2_if
// Bundles the data path, configuration and status signals of sync_fifo_v2.
//   master : producer/consumer side (drives wr_*, rd_en, cfg_*, err_clr)
//   slave  : the FIFO itself (drives rd_data*, status and error flags)
// Signals: wr_en, wr_data, rd_en, rd_data, rd_data_vld, cfg_almost_full,
//   cfg_almost_empty, err_clr, full, empty, almost_full, almost_empty,
//   fifo_num, overflow, underflow, rd_par_err (SYNC_FIFO_V2_PARITY_EN only).
//
// Handshake: a write is taken on a rising clk edge exactly when wr_en is high
// and full is low (full acts as the inverted ready); a read/pop is taken on a
// rising edge exactly when rd_en is high and empty is low. Requests made while
// the FIFO cannot accept them are dropped and flagged as overflow/underflow;
// the requester is never stalled.
// -----------------------------------------------------------------------------
interface sync_fifo_v2_if #(
  parameter int DEEPWID = 3,
  parameter int BITWID  = 5
);

  logic               wr_en;
  logic [BITWID-1:0]  wr_data;
  logic               rd_en;
  logic [BITWID-1:0]  rd_data;
  logic               rd_data_vld;
  logic [DEEPWID:0]   cfg_almost_full;
  logic [DEEPWID:0]   cfg_almost_empty;
  logic               err_clr;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [DEEPWID:0]   fifo_num;
  logic               overflow;
  logic               underflow;
`ifdef SYNC_FIFO_V2_PARITY_EN
  logic               rd_par_err;
`endif

  modport master (
    output wr_en, wr_data, rd_en, cfg_almost_full, cfg_almost_empty, err_clr,
    input  rd_data, rd_data_vld, full, empty, almost_full, almost_empty,
           fifo_num, overflow, underflow
`ifdef SYNC_FIFO_V2_PARITY_EN
    , input rd_par_err
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en, cfg_almost_full, cfg_almost_empty, err_clr,
    output rd_data, rd_data_vld, full, empty, almost_full, almost_empty,
           fifo_num, overflow, underflow
`ifdef SYNC_FIFO_V2_PARITY_EN
    , output rd_par_err
`endif
  );

endinterface

// File: rtl/sync_fifo_v2_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2_ram
// Storage array for sync_fifo_v2: synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address (AW bits)
//   wdata : write data (DW bits)
//   raddr : read address (AW bits)
//   rdata : combinational read data at raddr
// -----------------------------------------------------------------------------
module sync_fifo_v2_ram #(
  parameter int AW = 3,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2
// Single-clock FIFO, DEPTH = 2**DEEPWID words of BITWID bits, with a selectable
// read mode (FWFT = FIFO_MODE_STD: registered read with a one-cycle valid pulse;
// FWFT = FIFO_MODE_FWFT: head word shown continuously, rd_en pops it),
// programmable almost-full/almost-empty levels and sticky overflow/underflow
// flags cleared by err_clr.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_v2_if.slave (data path, configuration, status)
// Macro SYNC_FIFO_V2_PARITY_EN: store an even-parity bit per entry and report
// mismatches on the delivered word through bus.rd_par_err.
// -----------------------------------------------------------------------------
module sync_fifo_v2
  import sync_fifo_v2_pkg::*;
#(
  parameter int DEEPWID = 3,
  parameter int BITWID  = 5,
  parameter int FWFT    = FIFO_MODE_STD
) (
  input  logic          clk,
  input  logic          rst_n,
  sync_fifo_v2_if.slave bus
);

`ifdef SYNC_FIFO_V2_PARITY_EN
  localparam int MEMW = BITWID + 1;
`else
  localparam int MEMW = BITWID;
`endif

  localparam logic [DEEPWID:0] DEPTH_N = {1'b1, {DEEPWID{1'b0}}};
  localparam logic [DEEPWID:0] PTR_INC = {{DEEPWID{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so that full (difference DEPTH) and
  // empty (difference 0) stay distinct after any number of wraps.
  logic [DEEPWID:0]  wr_ptr;
  logic [DEEPWID:0]  rd_ptr;
  logic [DEEPWID:0]  fifo_num;
  logic              full_w;
  logic              empty_w;
  logic              wr_acc;
  logic              rd_acc;
  logic [DEEPWID:0]  af_margin;
  logic [DEEPWID:0]  af_level;
  logic              overflow_q;
  logic              underflow_q;
  logic [MEMW-1:0]   ram_wdata;
  logic [MEMW-1:0]   ram_rdata;
  logic [BITWID-1:0] rd_data_int;
  logic              rd_vld_int;

  assign fifo_num = wr_ptr - rd_ptr;
  assign full_w   = (fifo_num == DEPTH_N);
  assign empty_w  = (fifo_num == '0);

  // A full FIFO drops the write even if a read frees a slot in the same cycle.
  assign wr_acc = bus.wr_en && !full_w;
  assign rd_acc = bus.rd_en && !empty_w;

  // Margins beyond DEPTH clamp to DEPTH, making almost_full permanently high.
  assign af_margin = (bus.cfg_almost_full > DEPTH_N) ? DEPTH_N : bus.cfg_almost_full;
  assign af_level  = DEPTH_N - af_margin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_INC;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w)      overflow_q <= 1'b1;
      else if (bus.err_clr)         overflow_q <= 1'b0;
      if (bus.rd_en && empty_w)     underflow_q <= 1'b1;
      else if (bus.err_clr)         underflow_q <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_V2_PARITY_EN
  logic par_bad;
  assign ram_wdata = {even_parity(PARITY_MAX_W'(bus.wr_data)), bus.wr_data};
  assign par_bad   = even_parity(PARITY_MAX_W'(ram_rdata[BITWID-1:0])) != ram_rdata[BITWID];
  logic rd_par_err_int;
`else
  assign ram_wdata = bus.wr_data;
`endif

  sync_fifo_v2_ram #(
    .AW (DEEPWID),
    .DW (MEMW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[DEEPWID-1:0]),
    .wdata (ram_wdata),
    .raddr (rd_ptr[DEEPWID-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is visible straight from the array; rd_en only acknowledges it.
      assign rd_data_int = ram_rdata[BITWID-1:0];
      assign rd_vld_int  = !empty_w;
`ifdef SYNC_FIFO_V2_PARITY_EN
      assign rd_par_err_int = !empty_w && par_bad;
`endif
    end else begin : g_std
      logic [BITWID-1:0] rd_data_q;
      logic              rd_vld_q;
`ifdef SYNC_FIFO_V2_PARITY_EN
      logic              rd_par_q;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q <= '0;
          rd_vld_q  <= 1'b0;
`ifdef SYNC_FIFO_V2_PARITY_EN
          rd_par_q  <= 1'b0;
`endif
        end else begin
          rd_vld_q <= rd_acc;
          if (rd_acc) rd_data_q <= ram_rdata[BITWID-1:0];
`ifdef SYNC_FIFO_V2_PARITY_EN
          rd_par_q <= rd_acc && par_bad;
`endif
        end
      end
      assign rd_data_int = rd_data_q;
      assign rd_vld_int  = rd_vld_q;
`ifdef SYNC_FIFO_V2_PARITY_EN
      assign rd_par_err_int = rd_par_q;
`endif
    end
  endgenerate

  assign bus.rd_data      = rd_data_int;
  assign bus.rd_data_vld  = rd_vld_int;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (fifo_num >= af_level);
  assign bus.almost_empty = (fifo_num <= bus.cfg_almost_empty);
  assign bus.fifo_num     = fifo_num;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
`ifdef SYNC_FIFO_V2_PARITY_EN
  assign bus.rd_par_err   = rd_par_err_int;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_v2
// Runs a standard-mode and an FWFT-mode sync_fifo_v2 side by side on identical
// stimulus. One queue-based reference model (a list of stored words plus
// sticky error bits) gives the expected occupancy, flags and read data for
// both instances. Optional macro: SYNC_FIFO_V2_PARITY_EN adds the
// corrupted-entry parity step.
// -----------------------------------------------------------------------------
module tb_sync_fifo_v2;
  import sync_fifo_v2_pkg::*;

  localparam int DEEPWID = 3;
  localparam int BITWID  = 5;
  localparam int DEPTH   = 1 << DEEPWID;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
  end
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  sync_fifo_v2_if #(.DEEPWID(DEEPWID), .BITWID(BITWID)) s_if ();
  sync_fifo_v2_if #(.DEEPWID(DEEPWID), .BITWID(BITWID)) f_if ();

  sync_fifo_v2 #(.DEEPWID(DEEPWID), .BITWID(BITWID), .FWFT(FIFO_MODE_STD)) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  sync_fifo_v2 #(.DEEPWID(DEEPWID), .BITWID(BITWID), .FWFT(FIFO_MODE_FWFT)) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f_if.slave)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [BITWID-1:0] exp_q[$];
  logic [BITWID-1:0] last_rd;
  bit                ovf;
  bit                unf;
  bit                exp_vld;
  int                cfg_af;
  int                cfg_ae;
  int                n_checks;
  int                n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    int margin;
    n      = exp_q.size();
    margin = (cfg_af > DEPTH) ? DEPTH : cfg_af;
    check("std_num",   32'(s_if.fifo_num),     n);
    check("std_full",  32'(s_if.full),         (n == DEPTH));
    check("std_empty", 32'(s_if.empty),        (n == 0));
    check("std_af",    32'(s_if.almost_full),  (n >= DEPTH - margin));
    check("std_ae",    32'(s_if.almost_empty), (n <= cfg_ae));
    check("std_ovf",   32'(s_if.overflow),     ovf);
    check("std_unf",   32'(s_if.underflow),    unf);
    check("std_vld",   32'(s_if.rd_data_vld),  exp_vld);
    check("std_data",  32'(s_if.rd_data),      last_rd);
    check("fwft_num",  32'(f_if.fifo_num),     n);
    check("fwft_af",   32'(f_if.almost_full),  (n >= DEPTH - margin));
    check("fwft_ae",   32'(f_if.almost_empty), (n <= cfg_ae));
    check("fwft_ovf",  32'(f_if.overflow),     ovf);
    check("fwft_unf",  32'(f_if.underflow),    unf);
    check("fwft_vld",  32'(f_if.rd_data_vld),  (n != 0));
    if (n != 0) check("fwft_data", 32'(f_if.rd_data), exp_q[0]);
`ifdef SYNC_FIFO_V2_PARITY_EN
    check("std_par",   32'(s_if.rd_par_err),   0);
    check("fwft_par",  32'(f_if.rd_par_err),   0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int af, input int ae);
    cfg_af = af;
    cfg_ae = ae;
    s_if.cfg_almost_full  = (DEEPWID+1)'(af);
    f_if.cfg_almost_full  = (DEEPWID+1)'(af);
    s_if.cfg_almost_empty = (DEEPWID+1)'(ae);
    f_if.cfg_almost_empty = (DEEPWID+1)'(ae);
  endtask

  task automatic drive(input logic we, input logic [BITWID-1:0] wd, input logic re, input logic ec);
    s_if.wr_en = we;  s_if.wr_data = wd;  s_if.rd_en = re;  s_if.err_clr = ec;
    f_if.wr_en = we;  f_if.wr_data = wd;  f_if.rd_en = re;  f_if.err_clr = ec;
  endtask

  // One clock cycle: drive, clock, advance the model, check both DUTs.
  task automatic cycle(input logic we, input logic [BITWID-1:0] wd, input logic re, input logic ec);
    int  cnt;
    bit  w_ok;
    bit  r_ok;
    cnt  = exp_q.size();
    w_ok = we && (cnt < DEPTH);
    r_ok = re && (cnt > 0);
    drive(we, wd, re, ec);
    @(posedge clk);
    #1;
    if (we && cnt == DEPTH) ovf = 1'b1;
    else if (ec)            ovf = 1'b0;
    if (re && cnt == 0)     unf = 1'b1;
    else if (ec)            unf = 1'b0;
    if (r_ok) last_rd = exp_q.pop_front();
    if (w_ok) exp_q.push_back(wd);
    exp_vld = r_ok;
    check_all();
  endtask

  // Asserts reset away from any clock edge so the asynchronous clear is seen
  // before the next edge, then releases just after an edge.
  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    ovf     = 1'b0;
    unf     = 1'b0;
    last_rd = '0;
    exp_vld = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  logic [BITWID-1:0] plan_data [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    plan_data = '{5'd3, 5'd5, 5'd16, 5'd28, 5'd8, 5'd9, 5'd14, 5'd7};
    set_cfg(1, 2);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;

    // Reset state
    do_reset();

    // Fill to full; almost_full rises at 7, almost_empty falls at 3
    for (int i = 0; i < 8; i++) cycle(1'b1, plan_data[i], 1'b0, 1'b0);
    check("fill_full", 32'(s_if.full), 1);

    // Overflow: dropped write, sticky until err_clr
    cycle(1'b1, 5'd26, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("ovf_sticky", 32'(s_if.overflow), 1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(s_if.overflow), 0);

    // Write while full and read in the same cycle: write still dropped
    cycle(1'b1, 5'd30, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 5'd3, 1'b0, 1'b0);

    // Drain eight words, then read empty
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("unf_set", 32'(s_if.underflow), 1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    // Set beats clear: underflow again in the clearing cycle
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // FWFT head word appears without rd_en
    cycle(1'b1, 5'd17, 1'b0, 1'b0);
    check("fwft_head17", 32'(f_if.rd_data), 17);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Streaming with simultaneous write/read through pointer wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, BITWID'($urandom_range(0, 31)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, BITWID'($urandom_range(0, 31)), 1'b1, 1'b0);
      check("stream_num", 32'(s_if.fifo_num), 4);
    end

    // Random traffic with varying thresholds (including saturating margins)
    for (int seg = 0; seg < 8; seg++) begin
      int wp;
      int rp;
      set_cfg($urandom_range(0, 15), $urandom_range(0, 15));
      wp = $urandom_range(20, 80);
      rp = $urandom_range(20, 80);
      for (int i = 0; i < 30; i++) begin
        cycle(($urandom_range(0, 99) < wp), BITWID'($urandom_range(0, 31)),
              ($urandom_range(0, 99) < rp), ($urandom_range(0, 7) == 0));
      end
      if (seg == 4) do_reset();
    end

    // Reset with data in flight discards everything
    set_cfg(1, 2);
    for (int i = 0; i < 5; i++) cycle(1'b1, BITWID'($urandom_range(0, 31)), 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef SYNC_FIFO_V2_PARITY_EN
    // Corrupt the stored head word and expect a parity error on delivery
    do_reset();
    cycle(1'b1, 5'd17, 1'b0, 1'b0);
    u_std.u_ram.mem[0][0]  = ~u_std.u_ram.mem[0][0];
    u_fwft.u_ram.mem[0][0] = ~u_fwft.u_ram.mem[0][0];
    #1;
    check("fwft_par_bad", 32'(f_if.rd_par_err), 1);
    check("std_par_idle", 32'(s_if.rd_par_err), 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("std_par_bad",  32'(s_if.rd_par_err), 1);
    check("std_par_vld",  32'(s_if.rd_data_vld), 1);
    check("std_par_data", 32'(s_if.rd_data), 16);
    check("fwft_par_pop", 32'(f_if.rd_par_err), 0);
    void'(exp_q.pop_front());
    last_rd = 5'd16;
    exp_vld = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
